// File: rtl/ppsmon_pkg.sv
// Shared definitions for the PPS monitor: register map, status and control bit positions,
// and the lock-tolerance helper.
package ppsmon_pkg;

    typedef enum logic [2:0] {
        ADDR_STATUS  = 3'd0,
        ADDR_TIMEOUT = 3'd1,
        ADDR_PERIOD  = 3'd2,
        ADDR_STAMP   = 3'd3,
        ADDR_MIN     = 3'd4,
        ADDR_MAX     = 3'd5,
        ADDR_TOL     = 3'd6,
        ADDR_NOW     = 3'd7
    } reg_addr_e;

    localparam int unsigned ST_VALID    = 0;
    localparam int unsigned ST_TIMEOUT  = 1;
    localparam int unsigned ST_LOCKED   = 2;

    localparam int unsigned CTL_CLRTO   = 1;
    localparam int unsigned CTL_CLRSTAT = 31;

    // |period - nominal| <= tol, in 33-bit signed arithmetic so no operand can overflow.
    function automatic logic within_tol(input logic [31:0] period, input logic [31:0] nominal,
                                        input logic [31:0] tol);
        logic signed [32:0] diff;
        logic        [32:0] mag;
        diff = $signed({1'b0, period}) - $signed({1'b0, nominal});
        mag  = diff[32] ? 33'(-diff) : 33'(diff);
        return mag <= {1'b0, tol};
    endfunction

endpackage

// File: rtl/ppsmon_if.sv
// Wishbone-style register bus between a host and the PPS monitor.
interface ppsmon_if;

    logic        wb_cyc_stb;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        wb_ack;
    logic        wb_stall;
    logic [31:0] wb_rdata;

    modport master (
        output wb_cyc_stb, wb_we, wb_addr, wb_wdata,
        input  wb_ack, wb_stall, wb_rdata
    );

    modport slave (
        input  wb_cyc_stb, wb_we, wb_addr, wb_wdata,
        output wb_ack, wb_stall, wb_rdata
    );

endinterface

// File: rtl/ppsmon_sync.sv
// Two-flop synchronizer for the asynchronous PPS input plus a delay flop for rising-edge detect.
module ppsmon_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pps,
    output logic o_edge
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= i_pps;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign o_edge = s2_q & ~s3_q;

endmodule

// File: rtl/ppsmon.sv
// PPS receiver and period monitor: timestamps, period, lock and missing-pulse detection.
// Optional min/max period tracking is built when PPSMON_MINMAX_EN is defined.
module ppsmon
    import ppsmon_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY_HZ = 81_250_000,
    parameter int unsigned DEFAULT_TIMEOUT    = 90_000_000,
    parameter int unsigned DEFAULT_TOL        = 1000
) (
    input  logic    i_clk,
    input  logic    i_reset_n,
    input  logic    i_pps,
    ppsmon_if.slave wb,
    output logic    o_tick,
    output logic    o_int,
    output logic    o_locked
);

    logic        pps_edge;
    logic [31:0] now_q, since_q, stamp_q, period_q, timeout_q, tol_q;
    logic [31:0] period_sh_q, stamp_sh_q, rdata_q, rd_mux, min_rd, max_rd, period_new, status;
    logic [15:0] ecount_q;
    logic        valid_q, locked_q, timeout_flag_q, armed_q, tick_q, int_q, ack_q;
    logic        wr, rd, rd_status, clr_stat, clr_to, have_period, timeout_hit;
    reg_addr_e   addr;

    ppsmon_sync u_sync (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_pps    (i_pps),
        .o_edge   (pps_edge)
    );

    assign addr        = reg_addr_e'(wb.wb_addr);
    assign wr          = wb.wb_cyc_stb & wb.wb_we;
    assign rd          = wb.wb_cyc_stb & ~wb.wb_we;
    assign rd_status   = rd && (addr == ADDR_STATUS);
    assign clr_stat    = wr && (addr == ADDR_STATUS) && wb.wb_wdata[CTL_CLRSTAT];
    assign clr_to      = wr && (addr == ADDR_STATUS) && wb.wb_wdata[CTL_CLRTO];
    assign period_new  = since_q + 32'd1;
    // A stats clear on the edge cycle makes this the first edge, so it yields no period.
    assign have_period = pps_edge && (ecount_q != 16'd0) && !clr_stat;
    // armed_q limits the interrupt to one per gap even if the timeout register is rewritten.
    assign timeout_hit = armed_q && (timeout_q != 32'd0) && (since_q == timeout_q - 32'd1)
                         && !pps_edge;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            now_q          <= '0;
            since_q        <= '0;
            stamp_q        <= '0;
            period_q       <= '0;
            ecount_q       <= '0;
            valid_q        <= 1'b0;
            locked_q       <= 1'b0;
            timeout_flag_q <= 1'b0;
            armed_q        <= 1'b1;
            tick_q         <= 1'b0;
            int_q          <= 1'b0;
            timeout_q      <= DEFAULT_TIMEOUT;
            tol_q          <= DEFAULT_TOL;
            ack_q          <= 1'b0;
            rdata_q        <= '0;
            period_sh_q    <= '0;
            stamp_sh_q     <= '0;
        end else begin
            now_q  <= now_q + 32'd1;
            tick_q <= pps_edge;
            int_q  <= timeout_hit;

            if (pps_edge) begin
                since_q <= '0;
            end else if (since_q != '1) begin
                since_q <= since_q + 32'd1;
            end

            if (pps_edge) begin
                armed_q <= 1'b1;
            end else if (timeout_hit) begin
                armed_q <= 1'b0;
            end

            if (timeout_hit) begin
                timeout_flag_q <= 1'b1;
            end else if (clr_to) begin
                timeout_flag_q <= 1'b0;
            end

            if (clr_stat) begin
                period_q <= '0;
                stamp_q  <= '0;
                ecount_q <= '0;
                valid_q  <= 1'b0;
                locked_q <= 1'b0;
            end
            if (pps_edge) begin
                stamp_q  <= now_q;
                ecount_q <= clr_stat ? 16'd1 : ecount_q + 16'd1;
            end
            if (have_period) begin
                period_q <= period_new;
                valid_q  <= 1'b1;
                locked_q <= within_tol(period_new, CLOCK_FREQUENCY_HZ, tol_q);
            end
            if (timeout_hit) begin
                locked_q <= 1'b0;
            end

            if (wr && (addr == ADDR_TIMEOUT)) timeout_q <= wb.wb_wdata;
            if (wr && (addr == ADDR_TOL))     tol_q     <= wb.wb_wdata;

            ack_q <= wb.wb_cyc_stb;
            if (rd) rdata_q <= rd_mux;
            if (rd_status) begin
                period_sh_q <= period_q;
                stamp_sh_q  <= stamp_q;
            end
        end
    end

`ifdef PPSMON_MINMAX_EN
    logic [31:0] min_q, max_q, min_sh_q, max_sh_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            min_q    <= '1;
            max_q    <= '0;
            min_sh_q <= '0;
            max_sh_q <= '0;
        end else begin
            if (clr_stat) begin
                min_q <= '1;
                max_q <= '0;
            end else if (have_period) begin
                if (period_new < min_q) min_q <= period_new;
                if (period_new > max_q) max_q <= period_new;
            end
            if (rd_status) begin
                min_sh_q <= min_q;
                max_sh_q <= max_q;
            end
        end
    end

    assign min_rd = min_sh_q;
    assign max_rd = max_sh_q;
`else
    assign min_rd = '0;
    assign max_rd = '0;
`endif

    always_comb begin
        status              = '0;
        status[31:16]       = ecount_q;
        status[ST_LOCKED]   = locked_q;
        status[ST_TIMEOUT]  = timeout_flag_q;
        status[ST_VALID]    = valid_q;
    end

    always_comb begin
        rd_mux = '0;
        unique case (addr)
            ADDR_STATUS:  rd_mux = status;
            ADDR_TIMEOUT: rd_mux = timeout_q;
            ADDR_PERIOD:  rd_mux = period_sh_q;
            ADDR_STAMP:   rd_mux = stamp_sh_q;
            ADDR_MIN:     rd_mux = min_rd;
            ADDR_MAX:     rd_mux = max_rd;
            ADDR_TOL:     rd_mux = tol_q;
            ADDR_NOW:     rd_mux = now_q;
        endcase
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_stall = 1'b0;
    assign wb.wb_rdata = rdata_q;
    assign o_tick      = tick_q;
    assign o_int       = int_q;
    assign o_locked    = locked_q;

endmodule

// File: tb/tb_ppsmon.sv
// Directed bench for ppsmon: register reset values, timestamping, period/lock, timeout, min/max.
module tb_ppsmon;

`ifdef PPSMON_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic pps;
    logic tick, intr, locked;
    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    ppsmon_if bus ();

    ppsmon #(
        .CLOCK_FREQUENCY_HZ(1000),
        .DEFAULT_TIMEOUT   (1500),
        .DEFAULT_TOL       (100)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_pps    (pps),
        .wb       (bus),
        .o_tick   (tick),
        .o_int    (intr),
        .o_locked (locked)
    );

    always #5 clk = ~clk;

    // Reference cycle count: equals the free-running counter's value in each cycle.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All bus/pps tasks start and end at a negedge.
    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus.wb_cyc_stb = 1'b1;
        bus.wb_we      = 1'b0;
        bus.wb_addr    = a;
        @(negedge clk);
        bus.wb_cyc_stb = 1'b0;
        d = bus.wb_rdata;
        check("rd_ack", bus.wb_ack, 1'b1);
        @(negedge clk);
        check("rd_ack_once", bus.wb_ack, 1'b0);
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.wb_cyc_stb = 1'b1;
        bus.wb_we      = 1'b1;
        bus.wb_addr    = a;
        bus.wb_wdata   = d;
        @(negedge clk);
        bus.wb_cyc_stb = 1'b0;
        bus.wb_we      = 1'b0;
        check("wr_ack", bus.wb_ack, 1'b1);
        @(negedge clk);
    endtask

    // Raise pps so it is first sampled at the clock ending cycle t; the edge cycle is t+2.
    task automatic pulse(input int unsigned t, input bit clr, input logic exp_lock,
                         output int unsigned stamp);
        if (cyc > t) begin
            $display("FAIL schedule: cycle %0d already past %0d", cyc, t);
            $fatal(1, "schedule");
        end
        while (cyc < t) @(negedge clk);
        pps = 1'b1;
        @(negedge clk);
        check("tick_early", tick, 1'b0);
        @(negedge clk);
        stamp = cyc;
        if (clr) begin
            bus.wb_cyc_stb = 1'b1;
            bus.wb_we      = 1'b1;
            bus.wb_addr    = 3'd0;
            bus.wb_wdata   = 32'h8000_0000;
        end
        @(negedge clk);
        bus.wb_cyc_stb = 1'b0;
        bus.wb_we      = 1'b0;
        pps = 1'b0;
        check("tick", tick, 1'b1);
        check("lock_at_edge", locked, exp_lock);
        check("int_at_edge", intr, 1'b0);
        @(negedge clk);
        check("tick_width", tick, 1'b0);
    endtask

    logic [31:0] d;
    int unsigned t0, s, sk, tk, c, n_int, int_at;

    initial begin
        rst_n          = 1'b0;
        pps            = 1'b0;
        bus.wb_cyc_stb = 1'b0;
        bus.wb_we      = 1'b0;
        bus.wb_addr    = 3'd0;
        bus.wb_wdata   = 32'd0;
        repeat (5) @(negedge clk);
        check("rst_tick", tick, 1'b0);
        check("rst_int", intr, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_ack", bus.wb_ack, 1'b0);
        check("rst_stall", bus.wb_stall, 1'b0);
        check("rst_rdata", bus.wb_rdata, 32'd0);
        rst_n = 1'b1;

        rd_check("rst_period", 3'd2, 32'd0);
        rd_check("rst_min_shadow", 3'd4, 32'd0);
        rd_check("rst_max_shadow", 3'd5, 32'd0);
        rd_check("rst_status", 3'd0, 32'd0);
        rd_check("rst_timeout", 3'd1, 32'd1500);
        rd_check("rst_tol", 3'd6, 32'd100);
        rd_check("rst_min", 3'd4, MINMAX ? 32'hFFFF_FFFF : 32'd0);
        rd_check("rst_stamp", 3'd3, 32'd0);
        c = cyc;
        rd(3'd7, d);
        check("now", d, c);

        // Single edge: first edge gives a stamp but no period.
        t0 = cyc + 10;
        pulse(t0, 1'b0, 1'b0, s);
        rd_check("single_status", 3'd0, 32'h0001_0000);
        rd_check("single_stamp", 3'd3, s);
        check("single_stamp_abs", s, t0 + 2);

        // Steady lock at nominal spacing.
        pulse(t0 + 1000, 1'b0, 1'b1, s);
        pulse(t0 + 2000, 1'b0, 1'b1, s);
        rd_check("steady_status", 3'd0, 32'h0003_0005);
        rd_check("steady_period", 3'd2, 32'd1000);

        // Drift out of tolerance, then back in.
        pulse(t0 + 3200, 1'b0, 1'b0, s);
        rd_check("drift_status", 3'd0, 32'h0004_0001);
        rd_check("drift_period", 3'd2, 32'd1200);
        pulse(t0 + 4250, 1'b0, 1'b1, s);
        rd_check("relock_status", 3'd0, 32'h0005_0005);
        rd_check("relock_period", 3'd2, 32'd1050);
        rd_check("relock_min", 3'd4, MINMAX ? 32'd1000 : 32'd0);
        rd_check("relock_max", 3'd5, MINMAX ? 32'd1200 : 32'd0);

        // Plain stats clear, then 990/1010/1000 spacing.
        wr(3'd0, 32'h8000_0000);
        rd_check("clr_status", 3'd0, 32'd0);
        rd_check("clr_period", 3'd2, 32'd0);
        pulse(t0 + 5000, 1'b0, 1'b0, s);
        pulse(t0 + 5990, 1'b0, 1'b1, s);
        pulse(t0 + 7000, 1'b0, 1'b1, s);
        pulse(t0 + 8000, 1'b0, 1'b1, s);
        rd_check("mm_status", 3'd0, 32'h0004_0005);
        rd_check("mm_min", 3'd4, MINMAX ? 32'd990 : 32'd0);
        rd_check("mm_max", 3'd5, MINMAX ? 32'd1010 : 32'd0);
        rd_check("mm_period", 3'd2, 32'd1000);

        // Stats clear on the edge cycle: edge becomes the first edge.
        pulse(t0 + 9000, 1'b1, 1'b0, s);
        rd_check("clredge_status", 3'd0, 32'h0001_0000);
        rd_check("clredge_stamp", 3'd3, s);
        rd_check("clredge_period", 3'd2, 32'd0);
        rd_check("clredge_min", 3'd4, MINMAX ? 32'hFFFF_FFFF : 32'd0);

        // Lock again, then stop edges and expect a single timeout interrupt.
        tk = t0 + 10000;
        pulse(tk, 1'b0, 1'b1, sk);
        n_int  = 0;
        int_at = 0;
        while (cyc < tk + 1700) begin
            @(negedge clk);
            if (intr) begin
                n_int++;
                int_at = cyc;
            end
        end
        check("int_count", n_int, 32'd1);
        check("int_cycle", int_at, sk + 1501);
        check("to_locked", locked, 1'b0);
        rd_check("to_status", 3'd0, 32'h0002_0003);
        wr(3'd0, 32'h0000_0002);
        rd_check("toclr_status", 3'd0, 32'h0002_0001);

        // Next edge re-arms without a spurious interrupt.
        pulse(tk + 1800, 1'b0, 1'b0, s);
        n_int = 0;
        repeat (30) begin
            @(negedge clk);
            if (intr) n_int++;
        end
        check("post_int_count", n_int, 32'd0);
        rd_check("post_status", 3'd0, 32'h0003_0001);
        rd_check("post_period", 3'd2, 32'd1800);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
